// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SQUASH = 2'b01,
    HALT   = 2'b10
  } pc_seq_state_t;

  localparam int          PC_W   = 16;
  localparam logic [15:0] PC_INC = 16'h2;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[16];

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencing for the 5-stage pipeline.
// Optional feature: define PC_SEQ_PERF_EN to add stall/flush perf counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          FLUSH_SLOTS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [15:0] redirect_pc_i,
  input  logic        halt_decoded_i,
  input  logic        imem_ready_i,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus2_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        halted_o,
  output logic [1:0]  state_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_SQUASH = SQUASH;
  localparam logic [1:0] ST_HALT   = HALT;
  localparam logic [1:0] FLUSH_CNT = 2'(FLUSH_SLOTS);

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_plus2;
  logic [1:0]      cnt, cnt_nxt;
  logic            halted;
  logic            fetch_valid, flush, stall_event;
  logic            cout_unused;

  // Sequential increment; carry-out dropped so 0xFFFE wraps to 0x0000.
  rca_16bit u_inc (
    .a    (pc),
    .b    (PC_INC),
    .cin  (1'b0),
    .sum  (pc_plus2),
    .cout (cout_unused)
  );

  // Next-state / next-PC arbitration: redirect > halt > stall > imem > advance.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    cnt_nxt     = cnt;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    stall_event = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid_i) begin
          flush  = 1'b1;
          pc_nxt = {redirect_pc_i[15:1], 1'b0};
          if (FLUSH_SLOTS != 0) begin
            state_nxt = ST_SQUASH;
            cnt_nxt   = FLUSH_CNT;
          end
        end else if (halt_decoded_i) begin
          flush     = 1'b1;
          state_nxt = ST_HALT;
        end else if (stall_i) begin
          stall_event = 1'b1;
        end else if (imem_ready_i) begin
          fetch_valid = 1'b1;
          pc_nxt      = pc_plus2;
        end
      end
      ST_SQUASH: begin
        // Halt seen here is on the wrong path and is dropped.
        flush = 1'b1;
        if (redirect_valid_i) begin
          pc_nxt  = {redirect_pc_i[15:1], 1'b0};
          cnt_nxt = FLUSH_CNT;
        end else begin
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        // Frozen until reset.
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (!rst_n) begin
      fetch_valid = 1'b0;
      flush       = 1'b0;
      stall_event = 1'b0;
    end
  end

  // State, PC, squash counter and halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      cnt    <= 2'd0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      halted <= (state_nxt == ST_HALT);
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  // Saturating perf counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0;
      flush_cnt <= 16'h0;
    end else begin
      if (stall_event && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h1;
      if (flush && flush_cnt != 16'hFFFF)       flush_cnt <= flush_cnt + 16'h1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  // Perf counters not built.
`endif

  assign pc_o          = pc;
  assign pc_plus2_o    = pc_plus2;
  assign fetch_valid_o = fetch_valid;
  assign flush_o       = flush;
  assign halted_o      = halted;
  assign state_o       = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (FLUSH_SLOTS=1).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_valid_i, halt_decoded_i, imem_ready_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] pc_o, pc_plus2_o;
  logic        fetch_valid_o, flush_o, halted_o;
  logic [1:0]  state_o;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(16'h0000), .FLUSH_SLOTS(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_decoded_i   (halt_decoded_i),
    .imem_ready_i     (imem_ready_i),
    .pc_o             (pc_o),
    .pc_plus2_o       (pc_plus2_o),
    .fetch_valid_o    (fetch_valid_o),
    .flush_o          (flush_o),
    .halted_o         (halted_o),
    .state_o          (state_o)
`ifdef PC_SEQ_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time 2 units past the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 16'h0;
    halt_decoded_i = 1'b0; imem_ready_i = 1'b1;

    // Reset state
    cyc();
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_state", 16'(state_o), 16'h0);
    chk("rst_halted", 16'(halted_o), 16'h0);
    chk("rst_fv", 16'(fetch_valid_o), 16'h0);
    chk("rst_flush", 16'(flush_o), 16'h0);

    // 1. sequential fetch
    rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_o, 16'(2 * i));
      chk("seq_fv", 16'(fetch_valid_o), 16'h1);
      cyc();
    end
    chk("seq_plus2", pc_plus2_o, 16'h000A);
    for (int i = 0; i < 4; i++) cyc();
    chk("at_10", pc_o, 16'h0010);

    // 2. redirect with one squash slot, odd target
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0041; #1;
    chk("redir_flush0", 16'(flush_o), 16'h1);
    chk("redir_fv0", 16'(fetch_valid_o), 16'h0);
    cyc(); redirect_valid_i = 1'b0; #1;
    chk("redir_pc", pc_o, 16'h0040);
    chk("redir_state", 16'(state_o), 16'h1);
    chk("redir_flush1", 16'(flush_o), 16'h1);
    chk("redir_fv1", 16'(fetch_valid_o), 16'h0);
    cyc(); #1;
    chk("redir_resume_state", 16'(state_o), 16'h0);
    chk("redir_resume_fv", 16'(fetch_valid_o), 16'h1);
    chk("redir_resume_flush", 16'(flush_o), 16'h0);
    chk("redir_resume_pc", pc_o, 16'h0040);

    // 3. stall and redirect together: redirect wins
    stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 16'h0100; #1;
    chk("sr_flush", 16'(flush_o), 16'h1);
    cyc(); stall_i = 1'b0; redirect_valid_i = 1'b0; #1;
    chk("sr_pc", pc_o, 16'h0100);
    cyc(); #1;
    chk("sr_fv", 16'(fetch_valid_o), 16'h1);
    // plain stall holds pc without flush
    stall_i = 1'b1; #1;
    chk("stall_fv", 16'(fetch_valid_o), 16'h0);
    chk("stall_flush", 16'(flush_o), 16'h0);
    cyc(); #1;
    chk("stall_pc", pc_o, 16'h0100);
    // imem not ready holds pc
    stall_i = 1'b0; imem_ready_i = 1'b0; #1;
    chk("nrdy_fv", 16'(fetch_valid_o), 16'h0);
    cyc(); #1;
    chk("nrdy_pc", pc_o, 16'h0100);
    imem_ready_i = 1'b1;

    // 5. redirect during squash reloads pc and restarts count; halt ignored there
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0200;
    cyc(); redirect_pc_i = 16'hFFFF; halt_decoded_i = 1'b1; #1;
    chk("sq_state", 16'(state_o), 16'h1);
    chk("sq_fv", 16'(fetch_valid_o), 16'h0);
    cyc(); redirect_valid_i = 1'b0; #1;
    chk("sq_reload_pc", pc_o, 16'hFFFE);
    chk("sq_restart_state", 16'(state_o), 16'h1);
    cyc(); halt_decoded_i = 1'b0; #1;
    chk("sq_no_halt", 16'(state_o), 16'h0);
    chk("wrap_plus2", pc_plus2_o, 16'h0000);
    chk("wrap_fv", 16'(fetch_valid_o), 16'h1);
    cyc(); #1;
    chk("wrap_pc", pc_o, 16'h0000);

    // 4. halt at 0x0020
    for (int i = 0; i < 16; i++) cyc();
    #1;
    chk("at_20", pc_o, 16'h0020);
    halt_decoded_i = 1'b1; #1;
    chk("hlt_flush", 16'(flush_o), 16'h1);
    chk("hlt_fv", 16'(fetch_valid_o), 16'h0);
    cyc(); halt_decoded_i = 1'b0; #1;
    chk("hlt_pc", pc_o, 16'h0020);
    chk("hlt_halted", 16'(halted_o), 16'h1);
    chk("hlt_state", 16'(state_o), 16'h2);
    chk("hlt_flush_off", 16'(flush_o), 16'h0);
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0300; stall_i = 1'b1; #1;
    chk("hlt_redir_flush", 16'(flush_o), 16'h0);
    cyc(); cyc(); redirect_valid_i = 1'b0; stall_i = 1'b0; #1;
    chk("hlt_ign_pc", pc_o, 16'h0020);
    chk("hlt_ign_halted", 16'(halted_o), 16'h1);
    rst_n = 1'b0;
    cyc(); #1;
    chk("hlt_rst_pc", pc_o, 16'h0000);
    chk("hlt_rst_halted", 16'(halted_o), 16'h0);
    chk("hlt_rst_state", 16'(state_o), 16'h0);
    rst_n = 1'b1;

`ifdef PC_SEQ_PERF_EN
    // 6. perf counters: 3 stalls + 1 redirect
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("perf_rst_stall", stall_cnt_o, 16'h0);
    chk("perf_rst_flush", flush_cnt_o, 16'h0);
    stall_i = 1'b1;
    cyc(); cyc(); cyc();
    stall_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 16'h0080;
    cyc(); redirect_valid_i = 1'b0;
    cyc(); #1;
    chk("perf_stall", stall_cnt_o, 16'h0003);
    chk("perf_flush", flush_cnt_o, 16'h0002);
    force dut.flush_cnt = 16'hFFFF;
    #1; release dut.flush_cnt;
    redirect_valid_i = 1'b1;
    cyc(); redirect_valid_i = 1'b0; #1;
    chk("perf_sat", flush_cnt_o, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
